approx_err_monitor: RTL and testbench
=====================================

Name: approx_err_monitor

Overview:
- Streaming accuracy monitor downstream of the approximate 8x8 multiplier built from the approximate 4:2 compressor cells.
- Accepts operand pairs A, B together with the multiplier's approximate product.
- Computes the exact product internally and accumulates error statistics over a programmed window: error count, maximum error distance and summed error distance.
- Used in simulation and on FPGA to characterise the approximate datapath without a host-side golden model.

Parameters:
W, 8, operand width; products are 2W bits
CNT_W, 16, width of sample-count and error-count fields
SUM_W, 32, width of summed-error-distance accumulator

Ports:
Clk  input  1  clock, rising-edge
Rst  input  1  asynchronous active-high reset
Start  input  1  one-cycle pulse: clear statistics, latch NumSamples, begin window
NumSamples  input  CNT_W  samples in window, sampled on Start
In_Valid  input  1  sample present on A, B, P_Approx
In_Ready  output  1  monitor accepts sample this cycle
A  input  W  multiplicand, unsigned
B  input  W  multiplier, unsigned
P_Approx  input  2W  approximate product for A, B
Busy  output  1  window in progress (RUN or DRAIN)
Done  output  1  one-cycle pulse, statistics final
ErrCount  output  CNT_W  samples with nonzero error distance
MaxED  output  2W  largest error distance in window
SumED  output  SUM_W  saturating sum of error distances
Overflow  output  1  sticky: SumED saturated in this window

Behaviour:
- Reset, asynchronous: all outputs and internal registers go to 0; FSM enters IDLE.
- A sample is accepted when In_Valid and In_Ready are both 1 on a rising edge.
- FSM states and transitions:
  - IDLE: In_Ready=0, Busy=0. On Start, clear ErrCount, MaxED, SumED and Overflow, latch NumSamples and reset the accepted counter. Go to RUN, or to DONE if NumSamples=0.
  - RUN: Busy=1. In_Ready=1 while accepted < NumSamples. When the last sample is accepted, go to DRAIN.
  - DRAIN: Busy=1, In_Ready=0. Wait until the pipeline is empty (2 cycles after the last accept), then go to DONE.
  - DONE: Done=1 for exactly one cycle, Busy=0, then go to IDLE. Statistics hold their values until the next Start.
- Start outside IDLE is ignored. Start is honoured in DONE's following cycle (IDLE) only.
- In_Valid outside RUN, or after the window count is reached, is ignored: no accept, no state change.
- Pipeline, with one valid bit per stage:
  - Stage 1 registers exact = A*B (2W-bit, unsigned) and P_Approx.
  - Stage 2 registers ED = |exact - P_Approx|, 2W bits, computed without wrap via compare-then-subtract.
  - Stage 3 updates the statistics.
- Statistics update 2 cycles after the accept edge.
- Accumulation per valid stage-2 result:
  - ErrCount += 1 if ED != 0. Saturates at 2^CNT_W-1; cannot exceed NumSamples in practice.
  - MaxED = max(MaxED, ED).
  - SumED += ED, zero-extended. On overflow, SumED clamps to 2^SUM_W-1 and Overflow sets to 1, sticky until Start.
- Back-to-back accepts are allowed every cycle; throughput is one sample per cycle.
- There is no backpressure inside the pipeline; it never stalls.
- Reset mid-window aborts immediately: all pipeline valid bits and statistics clear, FSM returns to IDLE, and Done is not pulsed.

Test Plan:
- Reset then Start, NumSamples=0 -> Done pulses 2 cycles after Start; ErrCount=0, MaxED=0, SumED=0, Busy never high.
- NumSamples=1, A=3, B=5, P_Approx=15 -> ErrCount=0, MaxED=0, SumED=0; Done 4 cycles after accept (2 pipeline + DRAIN exit + DONE).
- NumSamples=3, one accept per cycle: (255,255,65000), (10,10,104), (7,9,63) -> ED = 25, 4, 0; ErrCount=2, MaxED=25, SumED=29.
- In_Valid toggled 1,0,1,0 with NumSamples=2, then In_Valid held high 5 more cycles -> exactly 2 accepts, In_Ready drops after the 2nd accept, extra samples leave the statistics unchanged.
- SUM_W=8, NumSamples=2: (255,255,65000), (255,255,64700) -> SumED=255 (saturated), Overflow=1, MaxED=325.
- Rst asserted in RUN after 1 of 3 accepts -> all outputs 0 in the same cycle (asynchronous), no Done; a subsequent Start runs a clean window.

Source files
------------

// File: rtl/approx_err_monitor_if.sv
// Bundles the monitor's control, sample and statistics signals.
// Drivers of samples use the master modport and the monitor uses the slave modport.
interface approx_err_monitor_if #(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int SUM_W = 32
);
   logic               Start;
   logic [CNT_W-1:0]   NumSamples;
   logic               In_Valid;
   logic               In_Ready;
   logic [W-1:0]       A;
   logic [W-1:0]       B;
   logic [2*W-1:0]     P_Approx;
   logic               Busy;
   logic               Done;
   logic [CNT_W-1:0]   ErrCount;
   logic [2*W-1:0]     MaxED;
   logic [SUM_W-1:0]   SumED;
   logic               Overflow;

   modport master (
      output Start, NumSamples, In_Valid, A, B, P_Approx,
      input  In_Ready, Busy, Done, ErrCount, MaxED, SumED, Overflow
   );

   modport slave (
      input  Start, NumSamples, In_Valid, A, B, P_Approx,
      output In_Ready, Busy, Done, ErrCount, MaxED, SumED, Overflow
   );
endinterface

// File: rtl/approx_err_monitor.sv
// Streaming error monitor for an approximate multiplier: recomputes the exact product
// and accumulates error count, maximum and saturating sum of error distances per window.
module approx_err_monitor #(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int SUM_W = 32
) (
   input  logic                 Clk,
   input  logic                 Rst,
   approx_err_monitor_if.slave  bus
);
   localparam int PW    = 2 * W;
   // Sum is formed one bit wider than the larger operand so a carry out is never lost.
   localparam int ACC_W = ((SUM_W > PW) ? SUM_W : PW) + 1;
   localparam logic [ACC_W-1:0] SUM_MAX = ACC_W'({SUM_W{1'b1}});

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [CNT_W-1:0]  acc_q, acc_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              s1_v_q, s1_v_d;
   logic [PW-1:0]     s1_exact_q, s1_exact_d;
   logic [PW-1:0]     s1_approx_q, s1_approx_d;
   logic              s2_v_q, s2_v_d;
   logic [PW-1:0]     s2_ed_q, s2_ed_d;

   logic [CNT_W-1:0]  err_q, err_d;
   logic [PW-1:0]     max_q, max_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic              ovf_q, ovf_d;

   logic              accept;
   logic              clear_stats;
   logic [ACC_W-1:0]  sum_ext;

   always_comb begin
      accept      = bus.In_Valid && in_ready_q;
      state_d     = state_q;
      num_d       = num_q;
      acc_d       = acc_q;
      clear_stats = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               clear_stats = 1'b1;
               num_d       = bus.NumSamples;
               acc_d       = '0;
               state_d     = (bus.NumSamples == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (accept) begin
               acc_d = acc_q + CNT_W'(1);
               if (acc_q + CNT_W'(1) == num_q) state_d = DRAIN;
            end
         end
         // Stage 1 empty means the last sample is in stage 2 and lands in the stats this edge.
         DRAIN: begin
            if (!s1_v_q) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == RUN) && (acc_d < num_d);
      busy_d     = (state_d == RUN) || (state_d == DRAIN);
      done_d     = (state_q == DONE);
   end

   always_comb begin
      s1_v_d      = accept;
      s1_exact_d  = s1_exact_q;
      s1_approx_d = s1_approx_q;
      if (accept) begin
         s1_exact_d  = PW'(bus.A) * PW'(bus.B);
         s1_approx_d = bus.P_Approx;
      end
      s2_v_d  = s1_v_q;
      s2_ed_d = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                            : (s1_approx_q - s1_exact_q);
   end

   always_comb begin
      err_d   = err_q;
      max_d   = max_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      sum_ext = ACC_W'(sum_q) + ACC_W'(s2_ed_q);
      if (clear_stats) begin
         err_d = '0;
         max_d = '0;
         sum_d = '0;
         ovf_d = 1'b0;
      end else if (s2_v_q) begin
         if ((s2_ed_q != '0) && (err_q != '1)) err_d = err_q + CNT_W'(1);
         if (s2_ed_q > max_q) max_d = s2_ed_q;
         if (sum_ext > SUM_MAX) begin
            sum_d = '1;
            ovf_d = 1'b1;
         end else begin
            sum_d = sum_ext[SUM_W-1:0];
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= IDLE;
         num_q       <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         s1_v_q      <= 1'b0;
         s1_exact_q  <= '0;
         s1_approx_q <= '0;
         s2_v_q      <= 1'b0;
         s2_ed_q     <= '0;
         err_q       <= '0;
         max_q       <= '0;
         sum_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         s1_v_q      <= s1_v_d;
         s1_exact_q  <= s1_exact_d;
         s1_approx_q <= s1_approx_d;
         s2_v_q      <= s2_v_d;
         s2_ed_q     <= s2_ed_d;
         err_q       <= err_d;
         max_q       <= max_d;
         sum_q       <= sum_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.In_Ready = in_ready_q;
   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;
   assign bus.ErrCount = err_q;
   assign bus.MaxED    = max_q;
   assign bus.SumED    = sum_q;
   assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: table-driven windows with a stats scoreboard,
// plus hand sequences for saturation and mid-window reset.
module tb_approx_err_monitor;
   localparam int W     = 8;
   localparam int CNT_W = 16;
   localparam int SUM_W = 32;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
      logic [2*W-1:0] ed;
   } sample_t;

   typedef struct {
      logic [CNT_W-1:0] errCount;
      logic [2*W-1:0]   maxEd;
      logic [SUM_W-1:0] sumEd;
      logic             overflow;
   } stats_t;

   logic clock = 1'b0;
   logic reset;

   approx_err_monitor_if #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus ();
   approx_err_monitor_if #(.W(W), .CNT_W(CNT_W), .SUM_W(8))     bus8 ();

   approx_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
      .Clk (clock),
      .Rst (reset),
      .bus (bus.slave)
   );

   approx_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(8)) dut8 (
      .Clk (clock),
      .Rst (reset),
      .bus (bus8.slave)
   );

   always #5 clock = ~clock;

   sample_t table_v [8];
   sample_t winQ [$];
   stats_t  sbQ [$];
   int      vectors;
   int      miscompares;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [2*W-1:0] distance(input logic [2*W-1:0] exact, input logic [2*W-1:0] p);
      return (exact >= p) ? (exact - p) : (p - exact);
   endfunction

   task automatic loadWindow(input int first, input int n);
      winQ.delete();
      for (int i = 0; i < n; i++) winQ.push_back(table_v[first + i]);
   endtask

   task automatic loadRandomWindow(input int n);
      sample_t s;
      logic [2*W:0] wide;
      winQ.delete();
      for (int i = 0; i < n; i++) begin
         s.a = W'($urandom_range(0, 255));
         s.b = W'($urandom_range(0, 255));
         wide = (2*W+1)'(s.a) * (2*W+1)'(s.b);
         case ($urandom_range(0, 3))
            0: s.p = wide[2*W-1:0];
            1: begin
               wide = wide + (2*W+1)'($urandom_range(0, 40));
               s.p  = wide[2*W] ? '1 : wide[2*W-1:0];
            end
            2: s.p = (wide[2*W-1:0] > 16'd40) ? wide[2*W-1:0] - 16'(($urandom_range(0, 40))) : '0;
            default: s.p = 16'($urandom);
         endcase
         s.ed = distance((2*W)'(s.a) * (2*W)'(s.b), s.p);
         winQ.push_back(s);
      end
   endtask

   // Runs one window on the 32-bit-sum instance; extraHigh keeps In_Valid high after the last accept.
   task automatic applyStimulus(input int n, input bit gapped, input int extraHigh);
      stats_t       exp;
      logic [32:0]  s;
      int accepts, budget, cnt, extra, phase;
      bit busySeen;
      exp = '{errCount: '0, maxEd: '0, sumEd: '0, overflow: 1'b0};
      for (int i = 0; i < n; i++) begin
         if (winQ[i].ed != '0) exp.errCount = exp.errCount + 1'b1;
         if (winQ[i].ed > exp.maxEd) exp.maxEd = winQ[i].ed;
         s = {1'b0, exp.sumEd} + 33'(winQ[i].ed);
         if (s[32]) begin
            exp.sumEd    = '1;
            exp.overflow = 1'b1;
         end else begin
            exp.sumEd = s[31:0];
         end
      end
      sbQ.push_back(exp);

      @(negedge clock);
      bus.Start      = 1'b1;
      bus.NumSamples = CNT_W'(n);
      @(negedge clock);
      bus.Start = 1'b0;

      accepts = 0;
      budget  = 0;
      phase   = 0;
      while (accepts < n && budget < 200) begin
         bus.In_Valid = gapped ? (phase % 2 == 0) : 1'b1;
         phase++;
         bus.A        = winQ[accepts].a;
         bus.B        = winQ[accepts].b;
         bus.P_Approx = winQ[accepts].p;
         if (bus.In_Valid && bus.In_Ready) accepts++;
         @(negedge clock);
         budget++;
      end
      if (n > 0) begin
         checkOutput("accept_cycles", budget, gapped ? 2 * n - 1 : n);
         checkOutput("in_ready_after_last", bus.In_Ready, 1'b0);
      end

      cnt      = 1;
      extra    = 0;
      busySeen = 1'b0;
      bus.A        = '0;
      bus.B        = '0;
      bus.P_Approx = 16'd100;
      while (!bus.Done && cnt <= 20) begin
         if (bus.Busy) busySeen = 1'b1;
         bus.In_Valid = (extra < extraHigh);
         extra++;
         if (bus.In_Valid && bus.In_Ready) accepts++;
         @(negedge clock);
         cnt++;
      end
      checkOutput("done_seen", bus.Done, 1'b1);
      checkOutput("done_latency", cnt, (n == 0) ? 2 : 4);
      checkOutput("busy_seen", busySeen, (n > 0));
      exp = sbQ.pop_front();
      checkOutput("err_count", bus.ErrCount, exp.errCount);
      checkOutput("max_ed", bus.MaxED, exp.maxEd);
      checkOutput("sum_ed", bus.SumED, exp.sumEd);
      checkOutput("overflow", bus.Overflow, exp.overflow);

      bus.In_Valid = (extra < extraHigh);
      extra++;
      if (bus.In_Valid && bus.In_Ready) accepts++;
      @(negedge clock);
      checkOutput("done_pulse_width", bus.Done, 1'b0);
      while (extra < extraHigh) begin
         bus.In_Valid = 1'b1;
         extra++;
         if (bus.In_Ready) accepts++;
         @(negedge clock);
      end
      bus.In_Valid = 1'b0;
      checkOutput("accept_total", accepts, n);
      checkOutput("sum_ed_hold", bus.SumED, exp.sumEd);
      checkOutput("err_count_hold", bus.ErrCount, exp.errCount);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt;
      bit doneSeen;
      bit busySeen;
      vectors     = 0;
      miscompares = 0;

      table_v[0] = '{8'd3,   8'd5,   16'd15,    16'd0};
      table_v[1] = '{8'd255, 8'd255, 16'd65000, 16'd25};
      table_v[2] = '{8'd10,  8'd10,  16'd104,   16'd4};
      table_v[3] = '{8'd7,   8'd9,   16'd63,    16'd0};
      table_v[4] = '{8'd200, 8'd100, 16'd20000, 16'd0};
      table_v[5] = '{8'd12,  8'd12,  16'd150,   16'd6};
      table_v[6] = '{8'd16,  8'd16,  16'd250,   16'd6};
      table_v[7] = '{8'd100, 8'd3,   16'd310,   16'd10};

      reset = 1'b1;
      bus.Start = 1'b0;  bus.NumSamples = '0; bus.In_Valid = 1'b0;
      bus.A = '0;        bus.B = '0;          bus.P_Approx = '0;
      bus8.Start = 1'b0; bus8.NumSamples = '0; bus8.In_Valid = 1'b0;
      bus8.A = '0;       bus8.B = '0;          bus8.P_Approx = '0;
      repeat (2) @(negedge clock);
      checkOutput("reset_in_ready", bus.In_Ready, 1'b0);
      checkOutput("reset_busy", bus.Busy, 1'b0);
      checkOutput("reset_done", bus.Done, 1'b0);
      checkOutput("reset_err_count", bus.ErrCount, 0);
      checkOutput("reset_max_ed", bus.MaxED, 0);
      checkOutput("reset_sum_ed", bus.SumED, 0);
      checkOutput("reset_overflow", bus.Overflow, 1'b0);
      reset = 1'b0;

      $display("[TB] empty window");
      winQ.delete();
      applyStimulus(0, 1'b0, 0);

      $display("[TB] single exact sample");
      loadWindow(0, 1);
      applyStimulus(1, 1'b0, 0);

      $display("[TB] three back-to-back samples");
      loadWindow(1, 3);
      applyStimulus(3, 1'b0, 0);

      $display("[TB] gapped valid then held high");
      loadWindow(4, 2);
      applyStimulus(2, 1'b1, 5);

      $display("[TB] random windows");
      for (int w = 0; w < 2; w++) begin
         loadRandomWindow(8);
         applyStimulus(8, 1'b0, 0);
      end

      $display("[TB] saturating sum on 8-bit accumulator");
      @(negedge clock);
      bus8.Start = 1'b1; bus8.NumSamples = 16'd2;
      @(negedge clock);
      bus8.Start = 1'b0;
      checkOutput("sat_in_ready", bus8.In_Ready, 1'b1);
      bus8.In_Valid = 1'b1; bus8.A = 8'd255; bus8.B = 8'd255; bus8.P_Approx = 16'd65000;
      @(negedge clock);
      bus8.P_Approx = 16'd64700;
      @(negedge clock);
      bus8.In_Valid = 1'b0;
      cnt = 0;
      while (!bus8.Done && cnt < 20) begin
         @(negedge clock);
         cnt++;
      end
      checkOutput("sat_done_seen", bus8.Done, 1'b1);
      checkOutput("sat_sum_ed", bus8.SumED, 255);
      checkOutput("sat_overflow", bus8.Overflow, 1'b1);
      checkOutput("sat_max_ed", bus8.MaxED, 325);
      checkOutput("sat_err_count", bus8.ErrCount, 2);

      $display("[TB] reset mid-window");
      @(negedge clock);
      bus.Start = 1'b1; bus.NumSamples = 16'd3;
      @(negedge clock);
      bus.Start = 1'b0;
      bus.In_Valid = 1'b1; bus.A = 8'd255; bus.B = 8'd255; bus.P_Approx = 16'd65000;
      @(negedge clock);
      bus.In_Valid = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("mid_err_count", bus.ErrCount, 1);
      checkOutput("mid_sum_ed", bus.SumED, 25);
      checkOutput("mid_busy", bus.Busy, 1'b1);
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", bus.Busy, 1'b0);
      checkOutput("abort_in_ready", bus.In_Ready, 1'b0);
      checkOutput("abort_err_count", bus.ErrCount, 0);
      checkOutput("abort_max_ed", bus.MaxED, 0);
      checkOutput("abort_sum_ed", bus.SumED, 0);
      checkOutput("abort_overflow", bus.Overflow, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      doneSeen = 1'b0;
      busySeen = 1'b0;
      repeat (6) begin
         @(negedge clock);
         if (bus.Done) doneSeen = 1'b1;
         if (bus.Busy) busySeen = 1'b1;
      end
      checkOutput("abort_no_done", doneSeen, 1'b0);
      checkOutput("abort_stays_idle", busySeen, 1'b0);

      $display("[TB] clean window after abort");
      loadWindow(6, 2);
      applyStimulus(2, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
